// File: rtl/mem_access_unit_if.sv
// Memory-port bundle between the load/store sequencer (master) and the memory (slave).
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [LANES-1:0]      mem_byte_enable;
    logic                  mem_resp;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: runs one word/byte, direct/indirect memory transaction per request
// and waits on mem_resp so the control FSM never tracks memory wait states.
module mem_access_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic                  indirect,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    mem_access_unit_if.master     mem
);
    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, IND_RD, ACCESS, DONE} state_t;

    state_t state, state_next;

    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [LANE_BITS-1:0]  lane_q;

    logic                  accept;
    logic                  enter_access;
    logic [ADDR_WIDTH-1:0] target;
    logic [1:0]            target_op;
    logic [DATA_WIDTH-1:0] target_wdata;
    logic [LANE_BITS-1:0]  target_lane;
    logic [LANES-1:0]      lane_onehot;
    logic [7:0]            lane_byte;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        word_align = {a[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        busy          = 1'b1;
        done          = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = indirect ? IND_RD : ACCESS;
            end
            IND_RD: begin
                mem.mem_read = 1'b1;
                if (mem.mem_resp) state_next = ACCESS;
            end
            ACCESS: begin
                if (op_q[1]) mem.mem_write = 1'b1;
                else         mem.mem_read  = 1'b1;
                if (mem.mem_resp) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The access address/op come from the request in IDLE, or from the pointer word in IND_RD.
    always_comb begin
        accept       = (state == IDLE) && start;
        enter_access = (accept && !indirect) || ((state == IND_RD) && mem.mem_resp);
        target       = addr;
        target_op    = op;
        target_wdata = wdata;
        if (state == IND_RD) begin
            target                   = '0;
            target[DATA_WIDTH-1:0]   = mem.mem_rdata;
            target_op                = op_q;
            target_wdata             = wdata_q;
        end
        target_lane = target_op[0] ? target[LANE_BITS-1:0] : '0;
        lane_onehot = '0;
        lane_onehot[target_lane] = 1'b1;
        lane_byte   = mem.mem_rdata[{lane_q, 3'b000} +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q                <= '0;
            wdata_q             <= '0;
            lane_q              <= '0;
            rdata               <= '0;
            mem.mem_address     <= '0;
            mem.mem_wdata       <= '0;
            mem.mem_byte_enable <= '0;
        end else begin
            if (accept) begin
                op_q            <= op;
                wdata_q         <= wdata;
                mem.mem_address <= word_align(addr);
            end
            // For a direct request this overrides the pointer address set above with the same value.
            if (enter_access) begin
                lane_q          <= target_lane;
                mem.mem_address <= word_align(target);
                if (target_op[1]) begin
                    mem.mem_wdata       <= target_op[0] ? {LANES{target_wdata[7:0]}} : target_wdata;
                    mem.mem_byte_enable <= target_op[0] ? lane_onehot : '1;
                end else begin
                    mem.mem_byte_enable <= '0;
                end
            end
            if ((state == ACCESS) && mem.mem_resp && !op_q[1]) begin
                rdata <= op_q[0] ? {{(DATA_WIDTH-8){1'b0}}, lane_byte} : mem.mem_rdata;
            end
        end
    end
endmodule
